// File: rtl/button_conditioner_pkg.sv
// Shared types and button index constants for the push-button front end.
// Auto-repeat stepping is enabled by defining BUTTON_AUTO_REPEAT_EN.
package button_conditioner_pkg;

  localparam int NUM_BTNS = 4;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } debounce_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One button: synchronizer, debounce FSM, optional auto-repeat stepping.
// Repeat logic exists only when BUTTON_AUTO_REPEAT_EN is defined.
module button_debouncer
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650_000,
  parameter int REPEAT_DELAY    = 32_500_000,
  parameter int REPEAT_PERIOD   = 6_500_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic step
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
    $error("button_debouncer: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  debounce_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync_q) begin
          state_d = PRESS_CHECK;
          cnt_d   = '0;
        end
      end
      PRESS_CHECK: begin
        if (!sync_q) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_CHECK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHECK: begin
        if (sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          step_q, step_d;

  // Reload after each repeat so later steps come every REPEAT_PERIOD.
  always_comb begin
    rcnt_d = rcnt_q;
    step_d = press_d;
    if (state_q == PRESS_CHECK && state_d == PRESSED) begin
      rcnt_d = '0;
    end else if (state_q != RELEASED && state_d == RELEASED) begin
      rcnt_d = '0;
    end else if (state_q == PRESSED && state_d == PRESSED) begin
      if (rcnt_q == RPT_LAST) begin
        step_d = 1'b1;
        rcnt_d = RPT_RELOAD;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rcnt_q <= '0;
      step_q <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = press_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: four independent debounced buttons, {d,u,r,l}.
// Defining BUTTON_AUTO_REPEAT_EN adds held-button repeat steps.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650_000,
  parameter int REPEAT_DELAY    = 32_500_000,
  parameter int REPEAT_PERIOD   = 6_500_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] btn_raw,
  output logic       btnl,
  output logic       btnr,
  output logic       btnu,
  output logic       btnd,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_step
);

  logic [NUM_BTNS-1:0] level;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_deb (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .raw   (btn_raw[i]),
      .level (level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i]),
      .step  (btn_step[i])
    );
  end

  assign btnl = level[BTN_L];
  assign btnr = level[BTN_R];
  assign btnu = level[BTN_U];
  assign btnd = level[BTN_D];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner, small debounce parameters.
// Works with or without BUTTON_AUTO_REPEAT_EN defined.
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int LAT  = SYNC + DEB + 1;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] btn_raw = 4'b0;
  logic       btnl, btnr, btnu, btnd;
  logic [3:0] btn_press, btn_release, btn_step;
  logic [3:0] lvl_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  button_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .btn_raw    (btn_raw),
    .btnl       (btnl),
    .btnr       (btnr),
    .btnu       (btnu),
    .btnd       (btnd),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_step   (btn_step)
  );

  assign lvl_v = {btnd, btnu, btnr, btnl};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a level flips once the delayed input has disagreed with it
  // for DEB+1 consecutive samples; repeats count held samples.
  logic [3:0] pipe [SYNC];
  logic [3:0] m_lvl, m_press, m_rel, m_step;
  int         run  [4];
  int         hold [4];
  logic       s_m;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int j = 0; j < SYNC; j++) pipe[j] = '0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_step = '0;
      for (int i = 0; i < 4; i++) begin
        run[i] = 0; hold[i] = 0;
      end
    end else begin
      m_press = '0; m_rel = '0; m_step = '0;
      for (int i = 0; i < 4; i++) begin
        s_m = pipe[SYNC-1][i];
        if (s_m != m_lvl[i]) begin
          run[i]++;
          if (run[i] == DEB + 1) begin
            m_lvl[i] = s_m;
            run[i]   = 0;
            hold[i]  = 0;
            if (s_m) begin
              m_press[i] = 1'b1;
              m_step[i]  = 1'b1;
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end else begin
          if (m_lvl[i] && run[i] == 0) begin
            hold[i]++;
`ifdef BUTTON_AUTO_REPEAT_EN
            if (hold[i] >= RD && (hold[i] - RD) % RP == 0) m_step[i] = 1'b1;
`endif
          end
          run[i] = 0;
        end
      end
      for (int j = SYNC - 1; j > 0; j--) pipe[j] = pipe[j-1];
      pipe[0] = btn_raw;
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("model_level", lvl_v, m_lvl);
      chk("model_press", btn_press, m_press);
      chk("model_release", btn_release, m_rel);
      chk("model_step", btn_step, m_step);
    end
  end

  task automatic wait_level(input int idx, input logic val, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (lvl_v[idx] != val && n < 40);
  endtask

  task automatic idle();
    repeat (LAT + 3) @(negedge clk_in);
  endtask

  initial begin
    int   n;
    logic saw;
    logic pat [7];
    int   mask, emask, extra_press;

    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (2) @(negedge clk_in);
    chk("reset_outputs",
        {lvl_v, btn_press, btn_release, btn_step}, 0);
    rst_in = 1'b0;
    idle();

    // clean press and release on left
    btn_raw[0] = 1'b1;
    wait_level(0, 1'b1, n);
    chk("press_latency", n, 7);
    chk("press_pulse", btn_press, 4'b0001);
    chk("press_step", btn_step, 4'b0001);
    chk("press_only_l", lvl_v, 4'b0001);
    @(negedge clk_in);
    chk("press_one_cycle", btn_press, 0);
    btn_raw[0] = 1'b0;
    wait_level(0, 1'b0, n);
    chk("release_latency", n, 7);
    chk("release_pulse", btn_release, 4'b0001);
    idle();

    // bounce on up never qualifies
    saw = 1'b0;
    for (int i = 0; i < 22; i++) begin
      btn_raw[2] = (i < 7) ? pat[i] : 1'b0;
      @(negedge clk_in);
      saw = saw | btnu | btn_press[2];
    end
    chk("bounce_rejected", saw, 0);

    // release glitch on right
    btn_raw[1] = 1'b1;
    wait_level(1, 1'b1, n);
    chk("r_press_latency", n, 7);
    saw = 1'b0;
    btn_raw[1] = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      saw = saw | !btnr | btn_release[1];
    end
    btn_raw[1] = 1'b1;
    repeat (15) begin
      @(negedge clk_in);
      saw = saw | !btnr | btn_release[1];
    end
    chk("glitch_held", saw, 0);
    btn_raw[1] = 1'b0;
    wait_level(1, 1'b0, n);
    chk("r_release_latency", n, 7);
    chk("r_release_pulse", btn_release, 4'b0010);
    idle();

    // simultaneous left+right
    btn_raw = 4'b0011;
    wait_level(0, 1'b1, n);
    chk("simul_latency", n, 7);
    chk("simul_levels", lvl_v, 4'b0011);
    chk("simul_press", btn_press, 4'b0011);
    btn_raw = 4'b0000;
    wait_level(0, 1'b0, n);
    idle();

    // async reset while down is being qualified
    btn_raw[0] = 1'b1;
    wait_level(0, 1'b1, n);
    btn_raw[3] = 1'b1;
    repeat (4) @(negedge clk_in);
    chk("pre_reset_level", lvl_v, 4'b0001);
    #3 rst_in = 1'b1;
    #1 chk("async_reset_outputs",
           {lvl_v, btn_press, btn_release, btn_step}, 0);
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b0;
    wait_level(3, 1'b1, n);
    chk("post_reset_latency", n, 7);
    chk("post_reset_press", btn_press, 4'b1001);
    btn_raw = 4'b0000;
    wait_level(3, 1'b0, n);
    idle();

    // long hold on left: repeat pattern
    btn_raw[0] = 1'b1;
    wait_level(0, 1'b1, n);
    chk("hold_first_step", btn_step[0], 1);
    mask = 0;
    extra_press = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_in);
      if (btn_step[0]) mask = mask | (1 << k);
      if (btn_press[0]) extra_press++;
    end
    emask = 0;
`ifdef BUTTON_AUTO_REPEAT_EN
    for (int k = RD; k <= 30; k += RP) emask = emask | (1 << k);
`endif
    chk("repeat_pattern", mask, emask);
    chk("repeat_no_press", extra_press, 0);
    btn_raw = 4'b0000;
    wait_level(0, 1'b0, n);
    chk("hold_release_latency", n, 7);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
